// File: rtl/mem_pkg.sv
// Shared defaults, controller state encoding and the queued request record
// for the memory request controller.
package mem_pkg;

  localparam int unsigned DefAddrW     = 5;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } state_e;

  typedef struct packed {
    logic                write;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Request queue: power-of-two depth, wrapping pointers, no push-to-pop bypass.
module req_fifo
  import mem_pkg::*;
#(
  parameter int unsigned Depth = DefFifoDepth,
  parameter type T = req_t,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [PtrW:0] count
);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers are exactly PtrW bits wide, so increment wraps modulo Depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Queues read/write requests and sequences them onto a registered byte memory,
// returning read data through a valid/ready response channel.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ctrl_req_t;

  ctrl_req_t                     push_req;
  ctrl_req_t                     head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          pop;

  state_e            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign req_ready = !fifo_full;
  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

  req_fifo #(
    .Depth (FIFO_DEPTH),
    .T     (ctrl_req_t)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          addr_d    = head.addr;
          data_in_d = head.wdata;
          read_d    = !head.write;
          write_d   = head.write;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = read_q ? StCapt : StIdle;
      end
      // Memory sampled the strobe on entry here, so data_out is now valid.
      StCapt: begin
        rsp_rdata_d = data_out;
        rsp_addr_d  = addr_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (fifo_count != '0) || (state_q != StIdle);

endmodule
